// File: rtl/lcd_touch_pkg.sv
// Shared types and constants for the touch-key controller.
// Contents: FSM state encoding, touch_data field positions, key/index/bound widths.
package lcd_touch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    DEBOUNCE = 3'd2,
    PRESSED  = 3'd3,
    LOCKED   = 3'd4
  } state_e;

  // touch_data layout: x in the upper half, y in the lower half
  localparam int unsigned TD_X_MSB = 31;
  localparam int unsigned TD_X_LSB = 16;
  localparam int unsigned TD_Y_MSB = 15;
  localparam int unsigned TD_Y_LSB = 0;

  localparam int unsigned KEY_W = 6;   // key_code width (8x8 grid max)
  localparam int unsigned IDX_W = 3;   // row/column index width
  localparam int unsigned BND_W = 17;  // bound arithmetic width; 16-bit coords never wrap

endpackage

// File: rtl/touch_hit_scan.sv
// Iterative hit-scan: walks column and row bounds in parallel, one cell per
// cycle, to locate (x,y) in the button grid without multipliers or dividers.
// Ports: sys_clk/sys_rst_n (sync, active low); start captures x/y; abort
// cancels a running scan silently; done pulses one cycle with hit/col/row.
module touch_hit_scan
  import lcd_touch_pkg::*;
#(
  parameter int unsigned GRID_X0 = 40,
  parameter int unsigned GRID_Y0 = 120,
  parameter int unsigned CELL_W  = 180,
  parameter int unsigned CELL_H  = 120,
  parameter int unsigned COLS    = 4,
  parameter int unsigned ROWS    = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] col,
  output logic [IDX_W-1:0] row
);

  logic             running;
  logic             under;
  logic [15:0]      x_q, y_q;
  logic [BND_W-1:0] col_bnd, row_bnd;
  logic             col_ok, row_ok;
  logic             col_in, row_in, col_miss, row_miss;

  // A coordinate equal to a bound falls into the next cell, hence strict '<'
  assign col_in   = col_ok | ({1'b0, x_q} < col_bnd);
  assign row_in   = row_ok | ({1'b0, y_q} < row_bnd);
  assign col_miss = !col_in && (col == IDX_W'(COLS - 1));
  assign row_miss = !row_in && (row == IDX_W'(ROWS - 1));

  // Bound walk
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      running <= 1'b0;
      under   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_bnd <= '0;
      row_bnd <= '0;
      col_ok  <= 1'b0;
      row_ok  <= 1'b0;
      col     <= '0;
      row     <= '0;
      done    <= 1'b0;
      hit     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        running <= 1'b0;
      end else if (start && !running) begin
        running <= 1'b1;
        x_q     <= x;
        y_q     <= y;
        under   <= (32'(x) < GRID_X0) || (32'(y) < GRID_Y0);
        col_bnd <= BND_W'(GRID_X0 + CELL_W);
        row_bnd <= BND_W'(GRID_Y0 + CELL_H);
        col_ok  <= 1'b0;
        row_ok  <= 1'b0;
        col     <= '0;
        row     <= '0;
      end else if (running) begin
        if (under || col_miss || row_miss) begin
          running <= 1'b0;
          done    <= 1'b1;
          hit     <= 1'b0;
        end else if (col_in && row_in) begin
          running <= 1'b0;
          done    <= 1'b1;
          hit     <= 1'b1;
        end else begin
          col_ok <= col_in;
          row_ok <= row_in;
          if (!col_in) begin
            col_bnd <= col_bnd + BND_W'(CELL_W);
            col     <= col + IDX_W'(1);
          end
          if (!row_in) begin
            row_bnd <= row_bnd + BND_W'(CELL_H);
            row     <= row + IDX_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/touch_key_ctrl.sv
// Touch-panel key controller: debounces grid hits into press events,
// generates auto-repeat while held, tracks hold/release, honours scan lockout.
// Ports: sys_clk/sys_rst_n (sync, active low); touch_data/touch_vld/touch_down
// raw samples; scan_en lockout; key_vld/key_code/key_repeat events; key_hold
// while pressed; busy while a hit-scan runs (samples dropped).
module touch_key_ctrl
  import lcd_touch_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned GRID_X0  = 40,
  parameter int unsigned GRID_Y0  = 120,
  parameter int unsigned CELL_W   = 180,
  parameter int unsigned CELL_H   = 120,
  parameter int unsigned COLS     = 4,
  parameter int unsigned ROWS     = 4,
  parameter int unsigned DEB_CNT  = 3,
  parameter int unsigned REL_CNT  = 3,
  parameter int unsigned LONG_MS  = 800,
  parameter int unsigned REP_MS   = 200
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [31:0]      touch_data,
  input  logic             touch_vld,
  input  logic             touch_down,
  input  logic             scan_en,
  output logic             key_vld,
  output logic [KEY_W-1:0] key_code,
  output logic             key_repeat,
  output logic             key_hold,
  output logic             busy
);

  localparam int unsigned MS_DIV = CLK_FREQ / 1000;
  localparam int unsigned MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int unsigned DEB_W  = $clog2(DEB_CNT + 1);
  localparam int unsigned REL_W  = $clog2(REL_CNT + 1);
  localparam int unsigned REP_W  = $clog2(LONG_MS + REP_MS + 1);

  state_e           state, state_n;
  logic [MS_W-1:0]  ms_cnt;
  logic             ms_tick;
  logic [KEY_W-1:0] cand, cand_n;
  logic [DEB_W-1:0] deb, deb_n, deb_inc;
  logic [REL_W-1:0] rel, rel_n, rel_inc;
  logic [REP_W-1:0] rep_cnt, rep_cnt_n, rep_tgt;
  logic             rep_phase, rep_phase_n;
  logic             key_vld_n, key_repeat_n, key_hold_n, busy_n;
  logic [KEY_W-1:0] key_code_n, hit_code;
  logic             scan_start, scan_done, scan_hit;
  logic [IDX_W-1:0] scan_col, scan_row;

  // Free-running 1 ms timebase
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ms_cnt  <= '0;
      ms_tick <= 1'b0;
    end else if (ms_cnt == MS_W'(MS_DIV - 1)) begin
      ms_cnt  <= '0;
      ms_tick <= 1'b1;
    end else begin
      ms_cnt  <= ms_cnt + MS_W'(1);
      ms_tick <= 1'b0;
    end
  end

  touch_hit_scan #(
    .GRID_X0 (GRID_X0),
    .GRID_Y0 (GRID_Y0),
    .CELL_W  (CELL_W),
    .CELL_H  (CELL_H),
    .COLS    (COLS),
    .ROWS    (ROWS)
  ) u_scan (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (scan_start),
    .abort     (!scan_en),
    .x         (touch_data[TD_X_MSB:TD_X_LSB]),
    .y         (touch_data[TD_Y_MSB:TD_Y_LSB]),
    .done      (scan_done),
    .hit       (scan_hit),
    .col       (scan_col),
    .row       (scan_row)
  );

  assign hit_code = KEY_W'(32'(scan_row) * COLS + 32'(scan_col));
  assign deb_inc  = deb + DEB_W'(1);
  assign rel_inc  = rel + REL_W'(1);
  assign rep_tgt  = rep_phase ? REP_W'(REP_MS - 1) : REP_W'(LONG_MS - 1);

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      key_vld    <= 1'b0;
      key_code   <= '0;
      key_repeat <= 1'b0;
      key_hold   <= 1'b0;
      busy       <= 1'b0;
      cand       <= '0;
      deb        <= '0;
      rel        <= '0;
      rep_cnt    <= '0;
      rep_phase  <= 1'b0;
    end else begin
      state      <= state_n;
      key_vld    <= key_vld_n;
      key_code   <= key_code_n;
      key_repeat <= key_repeat_n;
      key_hold   <= key_hold_n;
      busy       <= busy_n;
      cand       <= cand_n;
      deb        <= deb_n;
      rel        <= rel_n;
      rep_cnt    <= rep_cnt_n;
      rep_phase  <= rep_phase_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n      = state;
    key_vld_n    = 1'b0;
    key_code_n   = key_code;
    key_repeat_n = key_repeat;
    key_hold_n   = key_hold;
    cand_n       = cand;
    deb_n        = deb;
    rel_n        = rel;
    rep_cnt_n    = rep_cnt;
    rep_phase_n  = rep_phase;
    scan_start   = 1'b0;

    if (!scan_en) begin
      // Lockout beats everything; an in-flight scan is aborted by the scanner
      state_n     = LOCKED;
      key_hold_n  = 1'b0;
      deb_n       = '0;
      rel_n       = '0;
      rep_cnt_n   = '0;
      rep_phase_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          deb_n = '0;
          if (touch_vld && touch_down) begin
            scan_start = 1'b1;
            state_n    = SCAN;
          end
        end
        SCAN: begin
          // Samples arriving here are dropped
          if (scan_done) begin
            if (scan_hit) begin
              deb_n  = ((deb != '0) && (hit_code == cand)) ? deb_inc : DEB_W'(1);
              cand_n = hit_code;
              if (deb_n == DEB_W'(DEB_CNT)) begin
                state_n      = PRESSED;
                key_vld_n    = 1'b1;
                key_code_n   = hit_code;
                key_repeat_n = 1'b0;
                key_hold_n   = 1'b1;
                deb_n        = '0;
                rel_n        = '0;
                rep_cnt_n    = '0;
                rep_phase_n  = 1'b0;
              end else begin
                state_n = DEBOUNCE;
              end
            end else begin
              state_n = IDLE;
              deb_n   = '0;
            end
          end
        end
        DEBOUNCE: begin
          if (touch_vld) begin
            if (touch_down) begin
              scan_start = 1'b1;
              state_n    = SCAN;
            end else begin
              state_n = IDLE;
              deb_n   = '0;
            end
          end
        end
        PRESSED: begin
          // Coordinates are ignored while held: no sliding onto other keys
          if (touch_vld && !touch_down && (rel_inc == REL_W'(REL_CNT))) begin
            state_n    = IDLE;
            key_hold_n = 1'b0;
            rel_n      = '0;
          end else begin
            if (touch_vld) begin
              rel_n = touch_down ? '0 : rel_inc;
            end
            if (ms_tick) begin
              if (rep_cnt != rep_tgt) begin
                rep_cnt_n = rep_cnt + REP_W'(1);
              end else if (!key_vld) begin
                key_vld_n    = 1'b1;
                key_repeat_n = 1'b1;
                rep_cnt_n    = '0;
                rep_phase_n  = 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          if (touch_vld && !touch_down) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n == SCAN);
  end

endmodule

// File: tb/tb_touch_key_ctrl.sv
// Directed self-checking bench for touch_key_ctrl. CLK_FREQ is scaled to
// 10 kHz so one ms is 10 clocks; all other parameters keep their defaults.
module tb_touch_key_ctrl;
  import lcd_touch_pkg::*;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] touch_data;
  logic        touch_vld, touch_down, scan_en;
  logic        key_vld, key_repeat, key_hold, busy;
  logic [5:0]  key_code;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int ev_cnt  = 0;
  int ev_code [64];
  int ev_rep  [64];
  int ev_cyc  [64];
  logic kv_prev = 1'b0;
  logic consec  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  touch_key_ctrl #(.CLK_FREQ(10_000)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (sys_rst_n),
    .touch_data (touch_data),
    .touch_vld  (touch_vld),
    .touch_down (touch_down),
    .scan_en    (scan_en),
    .key_vld    (key_vld),
    .key_code   (key_code),
    .key_repeat (key_repeat),
    .key_hold   (key_hold),
    .busy       (busy)
  );

  // Event logger
  always @(negedge clk) begin
    if (key_vld === 1'b1) begin
      if (kv_prev) consec = 1'b1;
      if (ev_cnt < 64) begin
        ev_code[ev_cnt] = int'(key_code);
        ev_rep[ev_cnt]  = int'(key_repeat);
        ev_cyc[ev_cnt]  = cyc;
      end
      ev_cnt++;
    end
    kv_prev = (key_vld === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic send(input int x, input int y, input logic down);
    @(negedge clk);
    touch_vld  = 1'b1;
    touch_data = {16'(x), 16'(y)};
    touch_down = down;
    @(negedge clk);
    touch_vld = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  task automatic send_n(input int x, input int y, input logic down, input int n);
    for (int k = 0; k < n; k++) send(x, y, down);
  endtask

  int bx [5] = '{219, 220,  39, 760, 759};
  int by [5] = '{120, 120, 300, 300, 599};
  int bn [5] = '{  1,   1,   0,   0,   1};
  int bc [5] = '{  0,   1,   0,   0,  15};

  initial begin
    int base, press_cyc, nrep, d0;
    sys_rst_n  = 1'b0;
    scan_en    = 1'b1;
    touch_vld  = 1'b0;
    touch_down = 1'b0;
    touch_data = '0;
    repeat (3) @(negedge clk);
    check("rst_key_vld",    32'(key_vld), 0);
    check("rst_key_code",   32'(key_code), 0);
    check("rst_key_repeat", 32'(key_repeat), 0);
    check("rst_key_hold",   32'(key_hold), 0);
    check("rst_busy",       32'(busy), 0);
    check("rst_state",      32'(dut.state), 32'(IDLE));
    sys_rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: press at (400,300) -> row1,col2 -> code 6
    base = ev_cnt;
    send_n(400, 300, 1'b1, 3);
    check("press_cnt",    32'(ev_cnt - base), 1);
    check("press_code",   32'(ev_code[base]), 6);
    check("press_rep",    32'(ev_rep[base]), 0);
    check("press_hold",   32'(key_hold), 1);
    check("press_state",  32'(dut.state), 32'(PRESSED));

    // 2: hold 1300 ms -> repeats at 800, 1000, 1200 ms
    press_cyc = ev_cyc[base];
    while (cyc < press_cyc + 13000) send(400, 300, 1'b1);
    nrep = ev_cnt - base - 1;
    check("rep_count", 32'(nrep), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rep%0d_code", i), 32'(ev_code[base + 1 + i]), 6);
      check($sformatf("rep%0d_flag", i), 32'(ev_rep[base + 1 + i]), 1);
    end
    d0 = ev_cyc[base + 1] - press_cyc;
    check("rep_first_800ms", 32'((d0 >= 7991) && (d0 <= 8000)), 1);
    check("rep_period_a", 32'(ev_cyc[base + 2] - ev_cyc[base + 1]), 2000);
    check("rep_period_b", 32'(ev_cyc[base + 3] - ev_cyc[base + 2]), 2000);

    // Release: a touch between release samples restarts the count
    base = ev_cnt;
    send_n(400, 300, 1'b0, 2);
    send(400, 300, 1'b1);
    send_n(400, 300, 1'b0, 2);
    check("rel_restart_hold", 32'(key_hold), 1);
    send(400, 300, 1'b0);
    check("rel_hold",  32'(key_hold), 0);
    check("rel_state", 32'(dut.state), 32'(IDLE));
    repeat (40) @(negedge clk);
    check("rel_no_event", 32'(ev_cnt - base), 0);

    // 3: grid boundaries
    for (int i = 0; i < 5; i++) begin
      base = ev_cnt;
      send_n(bx[i], by[i], 1'b1, 3);
      check($sformatf("bnd%0d_cnt", i), 32'(ev_cnt - base), 32'(bn[i]));
      if (bn[i] != 0) check($sformatf("bnd%0d_code", i), 32'(ev_code[base]), 32'(bc[i]));
      send_n(0, 0, 1'b0, 3);
    end

    // Jitter 5,6,5 then 5,5: press only on the third consecutive 5
    base = ev_cnt;
    send(300, 300, 1'b1);
    send(400, 300, 1'b1);
    send(300, 300, 1'b1);
    check("jit_after3", 32'(ev_cnt - base), 0);
    send(300, 300, 1'b1);
    check("jit_after4", 32'(ev_cnt - base), 0);
    send(300, 300, 1'b1);
    check("jit_after5", 32'(ev_cnt - base), 1);
    check("jit_code",   32'(ev_code[base]), 5);
    send_n(0, 0, 1'b0, 3);

    // 4: sample during busy is dropped
    base = ev_cnt;
    @(negedge clk);
    touch_vld  = 1'b1;
    touch_data = {16'd400, 16'd300};
    touch_down = 1'b1;
    @(negedge clk);
    check("busy_high", 32'(busy), 1);
    touch_data = {16'd100, 16'd130};
    @(negedge clk);
    touch_vld = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_low",        32'(busy), 0);
    check("busy_code_held",  32'(key_code), 5);
    check("busy_state",      32'(dut.state), 32'(DEBOUNCE));
    send_n(400, 300, 1'b1, 2);
    check("busy_cnt",  32'(ev_cnt - base), 1);
    check("busy_code", 32'(ev_code[base]), 6);
    send_n(0, 0, 1'b0, 3);

    // 5: scan_en drop aborts the deciding scan; exit LOCKED only on release
    base = ev_cnt;
    send_n(400, 300, 1'b1, 2);
    @(negedge clk);
    touch_vld  = 1'b1;
    touch_data = {16'd400, 16'd300};
    touch_down = 1'b1;
    @(negedge clk);
    touch_vld = 1'b0;
    scan_en   = 1'b0;
    repeat (20) @(negedge clk);
    check("lock_no_event", 32'(ev_cnt - base), 0);
    check("lock_state",    32'(dut.state), 32'(LOCKED));
    check("lock_busy",     32'(busy), 0);
    scan_en = 1'b1;
    send(400, 300, 1'b1);
    check("lock_touched",  32'(dut.state), 32'(LOCKED));
    check("lock_hold",     32'(key_hold), 0);
    send(400, 300, 1'b0);
    check("lock_exit",     32'(dut.state), 32'(IDLE));
    check("lock_no_event2", 32'(ev_cnt - base), 0);

    // 6: reset during PRESSED
    send_n(220, 120, 1'b1, 3);
    check("pre_rst_state", 32'(dut.state), 32'(PRESSED));
    check("pre_rst_code",  32'(key_code), 1);
    @(negedge clk);
    sys_rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_hold",   32'(key_hold), 0);
    check("mid_rst_code",   32'(key_code), 0);
    check("mid_rst_vld",    32'(key_vld), 0);
    check("mid_rst_repeat", 32'(key_repeat), 0);
    check("mid_rst_busy",   32'(busy), 0);
    check("mid_rst_state",  32'(dut.state), 32'(IDLE));
    sys_rst_n = 1'b1;
    repeat (20) @(negedge clk);

    check("no_back_to_back_vld", 32'(consec), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
